// File: rtl/nerv_mem_pkg.sv
// nerv_mem_pkg: shared definitions for the single-port memory arbiter.
//   state_t      - sequencer states, also exported on the debug port
//   NOP          - instruction presented to the core after reset (addi x0,x0,0)
//   ILLEGAL_INSN - instruction returned for a fetch outside the memory
package nerv_mem_pkg;

  typedef enum logic [2:0] {
    S_SAMPLE  = 3'd0,
    S_DREQ    = 3'd1,
    S_DRSP    = 3'd2,
    S_IREQ    = 3'd3,
    S_IRSP    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] ILLEGAL_INSN = 32'h0000_0000;

endpackage

// File: rtl/nerv_mem_arb.sv
// nerv_mem_arb: serialises the core's per-cycle data access and instruction
// fetch onto one shared single-port memory and stalls the core until both
// results are registered.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   stall                   - to core, 1 = hold state; low for one cycle per bundle
//   imem_addr / imem_data   - fetch byte address in, registered instruction out
//   dmem_valid/addr/wstrb/wdata - data access in (wstrb==0 is a read)
//   dmem_rdata              - registered load data out
//   mem_req/we/addr/wstrb/wdata - shared memory request (word address)
//   mem_gnt, mem_rvalid, mem_rdata - memory accept / read response
//   dbg_state               - current sequencer state
//
// Memory handshake: mem_req is a registered request that stays asserted, with
// address/we/wstrb/wdata held constant, until the memory raises mem_gnt in the
// same cycle; the request is taken at that edge. Every granted read is answered
// later by exactly one mem_rvalid cycle carrying mem_rdata; rvalid is only
// honoured while waiting for a read response. we/wstrb/wdata are 0 whenever
// mem_req is 0.
module nerv_mem_arb
  import nerv_mem_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              clock,
  input  logic              reset,
  output logic              stall,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_data,
  input  logic              dmem_valid,
  input  logic [31:0]       dmem_addr,
  input  logic [3:0]        dmem_wstrb,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output state_t            dbg_state
);

  state_t      state;
  logic [31:0] i_addr_q;

  // Byte address lies inside the 4*2^MEM_AW byte memory based at 0.
  function automatic logic in_range(input logic [31:0] a);
    return (a >> (MEM_AW + 2)) == 32'd0;
  endfunction

  function automatic logic [MEM_AW-1:0] word_addr(input logic [31:0] a);
    return a[MEM_AW+1:2];
  endfunction

  // The fetch request is set up on the edge that enters S_IREQ. From S_SAMPLE
  // the latch is being written on that same edge, so use the live address.
  logic [31:0]       fetch_addr;
  logic              fetch_ok;
  logic [MEM_AW-1:0] fetch_word;

  always_comb begin
    fetch_addr = (state == S_SAMPLE) ? imem_addr : i_addr_q;
    fetch_ok   = in_range(fetch_addr);
    fetch_word = fetch_ok ? word_addr(fetch_addr) : '0;
  end

  assign dbg_state = state;

  // The mem_* registers double as the data-side latches: they are loaded in
  // S_SAMPLE and held unchanged for the whole data request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_SAMPLE;
      stall      <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      imem_data  <= NOP;
      dmem_rdata <= '0;
      i_addr_q   <= '0;
    end else begin
      case (state)
        S_SAMPLE: begin
          i_addr_q <= imem_addr;
          if (dmem_valid && in_range(dmem_addr)) begin
            state     <= S_DREQ;
            mem_req   <= 1'b1;
            mem_we    <= |dmem_wstrb;
            mem_addr  <= word_addr(dmem_addr);
            mem_wstrb <= dmem_wstrb;
            mem_wdata <= dmem_wdata;
          end else begin
            // Out-of-range stores vanish; out-of-range loads read as zero.
            if (dmem_valid && dmem_wstrb == 4'd0) dmem_rdata <= '0;
            state     <= S_IREQ;
            mem_req   <= fetch_ok;
            mem_we    <= 1'b0;
            mem_addr  <= fetch_word;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end
        end
        S_DREQ: begin
          if (mem_gnt) begin
            if (mem_we) begin
              // Store needs no response: chain the fetch request directly.
              state     <= S_IREQ;
              mem_req   <= fetch_ok;
              mem_addr  <= fetch_word;
            end else begin
              state     <= S_DRSP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
            end
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end
        end
        S_DRSP: begin
          if (mem_rvalid) begin
            dmem_rdata <= mem_rdata;
            state      <= S_IREQ;
            mem_req    <= fetch_ok;
            mem_addr   <= fetch_word;
          end
        end
        S_IREQ: begin
          if (!fetch_ok) begin
            imem_data <= ILLEGAL_INSN;
            stall     <= 1'b0;
            state     <= S_RELEASE;
          end else if (mem_gnt) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            state    <= S_IRSP;
          end
        end
        S_IRSP: begin
          if (mem_rvalid) begin
            imem_data <= mem_rdata;
            stall     <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          stall <= 1'b1;
          state <= S_SAMPLE;
        end
        default: begin
          stall   <= 1'b1;
          mem_req <= 1'b0;
          state   <= S_SAMPLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nerv_mem_arb.sv
// tb_nerv_mem_arb: drives bundles into nerv_mem_arb, plays the memory side,
// and checks transactions, latency and results against a bundle-level model.
module tb_nerv_mem_arb;
  import nerv_mem_pkg::*;

  localparam int MEM_AW = 14;
  localparam int W      = 1 + MEM_AW + 4 + 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              stall;
  logic [31:0]       imem_addr, imem_data;
  logic              dmem_valid;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]        dmem_wstrb;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata, mem_rdata;
  state_t            dbg_state;

  nerv_mem_arb #(.MEM_AW(MEM_AW)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [31:0]  mem_init [int];
  logic [31:0]  model_imem, model_dmem;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic bit in_rng(input logic [31:0] a);
    return a < (32'd1 << (MEM_AW + 2));
  endfunction

  function automatic logic [MEM_AW-1:0] to_word(input logic [31:0] a);
    return MEM_AW'(a / 4);
  endfunction

  function automatic logic [31:0] memval(input logic [MEM_AW-1:0] wa);
    if (mem_init.exists(int'(wa))) return mem_init[int'(wa)];
    return 32'hA500_0000 ^ ({18'd0, wa} * 32'd2654435761);
  endfunction

  // Read transactions carry no meaningful write data.
  function automatic logic [W-1:0] pack(input logic we, input logic [MEM_AW-1:0] wa,
                                        input logic [3:0] ws, input logic [31:0] wd);
    return {we, wa, ws, we ? wd : 32'd0};
  endfunction

  // ---------------- driver: one core bundle plus memory responder ----------------
  task automatic run_bundle(input string name, input bit dv, input logic [31:0] ia,
                            input logic [31:0] da, input logic [3:0] ws,
                            input logic [31:0] wd, input int gd, input int rd,
                            input int abort_cyc, input bit late_rv);
    int exp_lat, lat, wait_cnt, rv_cnt;
    bit rv_pend, req_act;
    logic [31:0]  rv_data;
    logic [W-1:0] held, cur;

    exp_q.delete();
    obs_q.delete();
    exp_lat = 2;  // sample cycle + release cycle
    if (dv && in_rng(da)) begin
      exp_q.push_back(pack(ws != 4'd0, to_word(da), ws, wd));
      exp_lat += 1 + gd + ((ws == 4'd0) ? 1 + rd : 0);
      if (ws == 4'd0) model_dmem = memval(to_word(da));
    end else if (dv && ws == 4'd0) begin
      model_dmem = 32'd0;
    end
    if (in_rng(ia)) begin
      exp_q.push_back(pack(1'b0, to_word(ia), 4'd0, 32'd0));
      exp_lat += 2 + gd + rd;
      model_imem = memval(to_word(ia));
    end else begin
      exp_lat += 1;
      model_imem = ILLEGAL_INSN;
    end

    imem_addr  = ia;
    dmem_valid = dv;
    dmem_addr  = da;
    dmem_wstrb = ws;
    dmem_wdata = wd;
    check($sformatf("%s/stall_at_sample", name), stall, 1'b1);

    lat = 0; wait_cnt = 0; rv_cnt = 0; rv_pend = 0; req_act = 0;
    rv_data = '0; held = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == abort_cyc) begin
        reset = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check($sformatf("%s/abort_stall", name), stall, 1'b1);
        check($sformatf("%s/abort_req", name), mem_req, 1'b0);
        check($sformatf("%s/abort_imem", name), imem_data, NOP);
        check($sformatf("%s/abort_dmem", name), dmem_rdata, 32'd0);
        model_imem = NOP;
        model_dmem = 32'd0;
        return;
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (cyc == 1 && late_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pend    = 0;
        end else begin
          rv_cnt--;
        end
      end
      cur = {mem_we, mem_addr, mem_wstrb, mem_we ? mem_wdata : 32'd0};
      if (req_act) begin
        check($sformatf("%s/req_hold", name), mem_req, 1'b1);
        check($sformatf("%s/req_stable", name), cur, held);
      end
      if (mem_req) begin
        if (wait_cnt == gd) begin
          mem_gnt = 1'b1;
          obs_q.push_back(cur);
          req_act = 0;
          wait_cnt = 0;
          if (!mem_we) begin
            rv_pend = 1;
            rv_cnt  = rd;
            rv_data = memval(mem_addr);
          end
        end else begin
          req_act = 1;
          held = cur;
          wait_cnt++;
        end
      end else begin
        check($sformatf("%s/idle_zero", name), {mem_we, mem_wstrb, mem_wdata}, 37'd0);
      end
      if (stall == 1'b0) begin
        lat = cyc;
        break;
      end
      @(negedge clock);
    end

    check($sformatf("%s/latency", name), lat, exp_lat);
    check($sformatf("%s/txn_count", name), obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s/txn%0d", name, i), obs_q[i], exp_q[i]);
    check($sformatf("%s/imem_data", name), imem_data, model_imem);
    check($sformatf("%s/dmem_rdata", name), dmem_rdata, model_dmem);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- directed + random sequence ----------------
  bit          r_dv;
  logic [31:0] r_ia, r_da, r_wd;
  logic [3:0]  r_ws;

  initial begin
    imem_addr = '0; dmem_valid = 0; dmem_addr = '0; dmem_wstrb = '0; dmem_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    mem_init[32'h40] = 32'h0050_0093;
    mem_init[32'h80] = 32'hDEAD_BEEF;
    mem_init[32'h41] = 32'h0000_0013;
    model_imem = NOP;
    model_dmem = 32'd0;

    repeat (3) @(negedge clock);
    check("rst/state", dbg_state, S_SAMPLE);
    check("rst/stall", stall, 1'b1);
    check("rst/req", mem_req, 1'b0);
    check("rst/we", mem_we, 1'b0);
    check("rst/addr", mem_addr, '0);
    check("rst/wstrb", mem_wstrb, 4'd0);
    check("rst/wdata", mem_wdata, 32'd0);
    check("rst/imem", imem_data, NOP);
    check("rst/dmem", dmem_rdata, 32'd0);

    reset = 1'b1;
    run_bundle("fetch", 0, 32'h100, 32'h0, 4'd0, 32'h0, 0, 0, 0, 0);
    run_bundle("load", 1, 32'h104, 32'h200, 4'd0, 32'h0, 0, 0, 0, 0);
    run_bundle("store", 1, 32'h108, 32'h300, 4'b0011, 32'h1234_ABCD, 3, 0, 0, 0);
    run_bundle("oor_load", 1, 32'h10C, 32'h0001_0000, 4'd0, 32'h0, 0, 0, 0, 0);
    run_bundle("oor_fetch", 0, 32'h8000_0000, 32'h0, 4'd0, 32'h0, 0, 0, 0, 0);

    // Reset while waiting for load data; rvalid keeps arriving afterwards.
    run_bundle("abort", 1, 32'h110, 32'h204, 4'd0, 32'h0, 0, 4, 4, 0);
    @(negedge clock);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("in_rst/stall", stall, 1'b1);
    check("in_rst/req", mem_req, 1'b0);
    check("in_rst/imem", imem_data, NOP);
    @(negedge clock);
    mem_rvalid = 1'b0;
    reset = 1'b1;
    run_bundle("after_rst", 1, 32'h114, 32'h208, 4'd0, 32'h0, 0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      r_dv = 1'($urandom_range(0, 1));
      r_ia = ($urandom_range(0, 7) == 0) ? (($urandom | 32'h0001_0000) & ~32'h3)
                                         : (32'($urandom_range(0, 16383)) << 2);
      r_da = ($urandom_range(0, 5) == 0) ? (($urandom | 32'h0100_0000) & ~32'h3)
                                         : (32'($urandom_range(0, 16383)) << 2);
      r_ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r_wd = $urandom;
      run_bundle($sformatf("rnd%0d", n), r_dv, r_ia, r_da, r_ws, r_wd,
                 $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
